// File: rtl/ascii_token_assembler_pkg.sv
// ascii_token_assembler_pkg: shared widths, ASCII constants, token state enum and byte helpers
package ascii_token_assembler_pkg;
  localparam int MAX_CHARS = 9;
  localparam int TOK_BITS = MAX_CHARS * 8;
  localparam int U_NUM_BITS = 4;
  localparam int LEN_BITS = 4;
  localparam logic [7:0] ASC_SP = 8'h20;
  localparam logic [7:0] ASC_LF = 8'h0A;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_BS = 8'h08;
  localparam logic [7:0] ASC_0 = 8'h30;
  localparam logic [7:0] ASC_9 = 8'h39;
  typedef enum logic [1:0] {TOK_IDLE, TOK_COLLECT, TOK_DISCARD} tok_state_e;
  function automatic logic is_term(input logic [7:0] c);
    return c == ASC_SP || c == ASC_LF || c == ASC_CR;
  endfunction
  function automatic logic is_print(input logic [7:0] c);
    return c >= 8'h21 && c <= 8'h7E;
  endfunction
  function automatic logic is_digit(input logic [7:0] c);
    return c >= ASC_0 && c <= ASC_9;
  endfunction
  // acc*10+d clamped to all-ones; the wide sum cannot overflow for any acc/d
  function automatic logic [U_NUM_BITS-1:0] sat_step(input logic [U_NUM_BITS-1:0] acc, input logic [3:0] d);
    logic [U_NUM_BITS+4:0] w;
    w = ({5'd0, acc} << 3) + ({5'd0, acc} << 1) + {{(U_NUM_BITS+1){1'b0}}, d};
    return w > {5'd0, {U_NUM_BITS{1'b1}}} ? '1 : w[U_NUM_BITS-1:0];
  endfunction
endpackage

// File: rtl/ascii_token_assembler_if.sv
// ascii_token_assembler_if: character input and token output bundle
interface ascii_token_assembler_if;
  import ascii_token_assembler_pkg::*;
  logic i_char_valid;
  logic [7:0] i_char;
  logic [TOK_BITS-1:0] o_a;
  logic [LEN_BITS-1:0] o_len;
  logic [U_NUM_BITS-1:0] o_u;
  logic o_u_valid;
  logic o_rdy;
  logic o_err;
  modport master (output i_char_valid, i_char, input o_a, o_len, o_u, o_u_valid, o_rdy, o_err);
  modport slave (input i_char_valid, i_char, output o_a, o_len, o_u, o_u_valid, o_rdy, o_err);
endinterface

// File: rtl/ascii_digit_accum.sv
// ascii_digit_accum: saturating decimal accumulator with digit flag; ASCII_TOKEN_BACKSPACE_EN adds history rebuild
module ascii_digit_accum
  import ascii_token_assembler_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_first,
  input  logic i_step,
  input  logic i_bs,
  input  logic [7:0] i_char,
  input  logic [LEN_BITS-1:0] i_cnt,
  output logic [U_NUM_BITS-1:0] o_acc,
  output logic o_digit
);
  logic [U_NUM_BITS-1:0] acc_q, acc_d;
  logic dig_q, dig_d;
  logic isd;
  assign isd = is_digit(i_char);
  assign o_acc = dig_q ? acc_q : '0;
  assign o_digit = dig_q;
`ifdef ASCII_TOKEN_BACKSPACE_EN
  logic [MAX_CHARS*4-1:0] hist_q, hist_d;
  logic [MAX_CHARS-1:0] isd_q, isd_d;
  // push or pop per-char digit history; a pop rebuilds the value from the surviving digits
  always_comb begin
    hist_d = hist_q;
    isd_d = isd_q;
    acc_d = acc_q;
    dig_d = dig_q;
    if (i_first) begin
      hist_d = (MAX_CHARS*4)'(i_char[3:0]);
      isd_d = MAX_CHARS'(isd);
      acc_d = sat_step('0, i_char[3:0]);
      dig_d = isd;
    end else if (i_step) begin
      hist_d = {hist_q[MAX_CHARS*4-5:0], i_char[3:0]};
      isd_d = {isd_q[MAX_CHARS-2:0], isd};
      acc_d = sat_step(acc_q, i_char[3:0]);
      dig_d = dig_q & isd;
    end else if (i_bs) begin
      hist_d = hist_q >> 4;
      isd_d = isd_q >> 1;
      acc_d = '0;
      dig_d = 1'b1;
      for (int k = MAX_CHARS - 1; k >= 0; k--)
        if (k < int'(i_cnt) - 1) begin
          acc_d = sat_step(acc_d, hist_d[k*4+:4]);
          dig_d = dig_d & isd_d[k];
        end
    end
  end
  // history registers
  always_ff @(posedge i_clk)
    if (!i_reset_n) begin
      hist_q <= '0;
      isd_q <= '0;
    end else begin
      hist_q <= hist_d;
      isd_q <= isd_d;
    end
`else
  logic unused_bs;
  assign unused_bs = ^{i_bs, i_cnt};
  // restart on the first char, extend on later chars, otherwise hold
  always_comb begin
    acc_d = i_first ? sat_step('0, i_char[3:0]) : i_step ? sat_step(acc_q, i_char[3:0]) : acc_q;
    dig_d = i_first ? isd : i_step ? dig_q & isd : dig_q;
  end
`endif
  // accumulator and digit flag
  always_ff @(posedge i_clk)
    if (!i_reset_n) begin
      acc_q <= '0;
      dig_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      dig_q <= dig_d;
    end
endmodule

// File: rtl/ascii_token_assembler.sv
// ascii_token_assembler: splits an ASCII byte stream into whitespace tokens; ASCII_TOKEN_BACKSPACE_EN enables 0x08 editing
module ascii_token_assembler
  import ascii_token_assembler_pkg::*;
(
  input logic i_clk,
  input logic i_reset_n,
  ascii_token_assembler_if.slave bus
);
  localparam logic [LEN_BITS-1:0] MAXC = LEN_BITS'(MAX_CHARS);
  localparam logic [LEN_BITS-1:0] ONE = LEN_BITS'(1);
  tok_state_e state_q;
  logic [TOK_BITS-1:0] work_q, a_q;
  logic [LEN_BITS-1:0] cnt_q, len_q;
  logic [U_NUM_BITS-1:0] u_q, acc;
  logic uv_q, rdy_q, err_q, dig;
  logic [7:0] c;
  logic v, term, prnt, bs;
  assign v = bus.i_char_valid;
  assign c = bus.i_char;
  assign term = is_term(c);
  assign prnt = is_print(c);
`ifdef ASCII_TOKEN_BACKSPACE_EN
  assign bs = c == ASC_BS;
`else
  assign bs = 1'b0;
`endif
  ascii_digit_accum u_acc (
    .i_clk(i_clk),
    .i_reset_n(i_reset_n),
    .i_first(v && state_q == TOK_IDLE && prnt),
    .i_step(v && state_q == TOK_COLLECT && prnt && cnt_q != MAXC),
    .i_bs(v && state_q == TOK_COLLECT && bs),
    .i_char(c),
    .i_cnt(cnt_q),
    .o_acc(acc),
    .o_digit(dig)
  );
  assign bus.o_a = a_q;
  assign bus.o_len = len_q;
  assign bus.o_u = u_q;
  assign bus.o_u_valid = uv_q;
  assign bus.o_rdy = rdy_q;
  assign bus.o_err = err_q;
  // token FSM with registered emit outputs; rdy/err are single-cycle pulses
  always_ff @(posedge i_clk)
    if (!i_reset_n) begin
      state_q <= TOK_IDLE;
      work_q <= '0;
      cnt_q <= '0;
      a_q <= '0;
      len_q <= '0;
      u_q <= '0;
      uv_q <= 1'b0;
      rdy_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      err_q <= 1'b0;
      if (v)
        case (state_q)
          TOK_IDLE:
            if (prnt) begin
              work_q <= TOK_BITS'(c);
              cnt_q <= ONE;
              state_q <= TOK_COLLECT;
            end else if (!term && !bs) state_q <= TOK_DISCARD;
          TOK_COLLECT:
            if (term) begin
              rdy_q <= 1'b1;
              a_q <= work_q;
              len_q <= cnt_q;
              u_q <= acc;
              uv_q <= dig;
              state_q <= TOK_IDLE;
            end else if (bs) begin
              work_q <= work_q >> 8;
              cnt_q <= cnt_q - ONE;
              if (cnt_q == ONE) state_q <= TOK_IDLE;
            end else if (prnt && cnt_q != MAXC) begin
              work_q <= {work_q[TOK_BITS-9:0], c};
              cnt_q <= cnt_q + ONE;
            end else state_q <= TOK_DISCARD;
          TOK_DISCARD:
            if (term) begin
              rdy_q <= 1'b1;
              err_q <= 1'b1;
              a_q <= '0;
              len_q <= '0;
              u_q <= '0;
              uv_q <= 1'b0;
              state_q <= TOK_IDLE;
            end
          default: state_q <= TOK_IDLE;
        endcase
    end
endmodule

// File: tb/tb_ascii_token_assembler.sv
// tb_ascii_token_assembler: directed and random byte streams checked against a queue-based token model
module tb_ascii_token_assembler;
  import ascii_token_assembler_pkg::*;
  logic i_clk = 1'b0;
  logic i_reset_n;
  always #5 i_clk = ~i_clk;
  ascii_token_assembler_if bus();
  ascii_token_assembler dut (.i_clk(i_clk), .i_reset_n(i_reset_n), .bus(bus));
  int errors = 0;
  int checks = 0;
  logic [7:0] tok[$];
  bit in_tok, bad;
  logic [TOK_BITS-1:0] exp_a;
  logic [LEN_BITS-1:0] exp_len;
  logic [U_NUM_BITS-1:0] exp_u;
  logic exp_uv, exp_rdy, exp_err;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic check_all();
    check("rdy", 128'(bus.o_rdy), 128'(exp_rdy));
    check("err", 128'(bus.o_err), 128'(exp_err));
    check("a", 128'(bus.o_a), 128'(exp_a));
    check("len", 128'(bus.o_len), 128'(exp_len));
    check("u", 128'(bus.o_u), 128'(exp_u));
    check("u_valid", 128'(bus.o_u_valid), 128'(exp_uv));
  endtask
  task automatic model_clear();
    tok.delete();
    in_tok = 0;
    bad = 0;
    {exp_a, exp_len, exp_u, exp_uv, exp_rdy, exp_err} = '0;
  endtask
  task automatic emit(input bit e);
    longint val;
    bit all_dig;
    exp_rdy = 1;
    exp_err = e;
    exp_a = '0;
    exp_len = '0;
    exp_u = '0;
    exp_uv = 0;
    if (!e) begin
      val = 0;
      all_dig = 1;
      foreach (tok[i]) begin
        exp_a = (exp_a << 8) | TOK_BITS'(tok[i]);
        if (tok[i] >= "0" && tok[i] <= "9") val = val * 10 + longint'(tok[i] - "0");
        else all_dig = 0;
      end
      exp_len = LEN_BITS'(tok.size());
      exp_uv = all_dig;
      if (all_dig) exp_u = val > longint'(2 ** U_NUM_BITS - 1) ? '1 : U_NUM_BITS'(val);
    end
    tok.delete();
  endtask
  task automatic model_byte(input logic [7:0] c);
    bit t, p, b;
    t = c == 8'h20 || c == 8'h0A || c == 8'h0D;
    p = c >= 8'h21 && c <= 8'h7E;
`ifdef ASCII_TOKEN_BACKSPACE_EN
    b = c == 8'h08;
`else
    b = 0;
`endif
    if (bad) begin
      if (t) begin
        emit(1);
        bad = 0;
      end
    end else if (!in_tok) begin
      if (p) begin
        tok.push_back(c);
        in_tok = 1;
      end else if (!t && !b) bad = 1;
    end else if (t) begin
      emit(0);
      in_tok = 0;
    end else if (b) begin
      void'(tok.pop_back());
      if (tok.size() == 0) in_tok = 0;
    end else if (p && tok.size() < MAX_CHARS) tok.push_back(c);
    else begin
      tok.delete();
      in_tok = 0;
      bad = 1;
    end
  endtask
  task automatic step(input logic v, input logic [7:0] c);
    bus.i_char_valid = v;
    bus.i_char = c;
    exp_rdy = 0;
    exp_err = 0;
    if (v) model_byte(c);
    @(posedge i_clk);
    #1;
    check_all();
  endtask
  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i]);
  endtask
  task automatic do_reset();
    i_reset_n = 1'b0;
    bus.i_char_valid = 1'b1;
    bus.i_char = "Q";
    @(posedge i_clk);
    #1;
    model_clear();
    i_reset_n = 1'b1;
    bus.i_char_valid = 1'b0;
    check_all();
  endtask
  task automatic rand_token();
    int n, r;
    logic [7:0] c;
    n = $urandom_range(1, 11);
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 99);
      c = r < 45 ? 8'($urandom_range(8'h30, 8'h39)) : r < 92 ? 8'($urandom_range(8'h21, 8'h7E)) :
          r < 96 ? 8'h08 : 8'($urandom_range(0, 3) == 0 ? 8'h01 : $urandom_range(8'h7F, 8'hFF));
      step(1'b1, c);
      if ($urandom_range(0, 5) == 0) step(1'b0, 8'($urandom));
    end
    r = $urandom_range(0, 2);
    step(1'b1, r == 0 ? 8'h20 : r == 1 ? 8'h0A : 8'h0D);
    if ($urandom_range(0, 3) == 0) step(1'b1, 8'h20);
  endtask
  initial begin
    i_reset_n = 1'b0;
    bus.i_char_valid = 1'b0;
    bus.i_char = 8'h00;
    repeat (2) @(posedge i_clk);
    #1;
    do_reset();
    send("Buy\n");
    check("buy_a", 128'(bus.o_a), 128'h427579);
    send("  AddItem 12 ");
    check("num_u", 128'(bus.o_u), 128'd12);
    send("99\r");
    check("sat_u", 128'(bus.o_u), 128'd15);
    send("ABCDEFGHIJ ");
    send("Cmd ");
    send("ABCDEFGHI ");
    send("A B ");
    send("Lo");
    step(1'b1, 8'h01);
    send("g\n");
    send("Lx");
    step(1'b1, 8'h08);
    send("ogin\n");
    step(1'b1, "Z");
    step(1'b1, 8'h08);
    send(" 7 ");
    send("Logou");
    do_reset();
    send("Login\n");
    check("login_len", 128'(bus.o_len), 128'd5);
    for (int i = 0; i < 400; i++) begin
      rand_token();
      if ($urandom_range(0, 60) == 0) do_reset();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
